// File: rtl/operand_fetch.sv
// Decode and operand-fetch stage: decodes one instruction per cycle, reads the
// 8x16 register file with same-cycle writeback bypass, and holds operands for execute.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_instr,
    output logic              in_ready,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [4:0]        ex_shamt,
    output logic [3:0]        ex_opcode,
    output logic [2:0]        ex_func,
    output logic [2:0]        ex_rd,
    output logic              ex_illegal
);

    logic [DATA_W-1:0] rf_q [NREG];

    logic              accept_s;
    logic [2:0]        rs_s;
    logic [2:0]        rt_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;

    logic [DATA_W-1:0] a_d, b_d, a_q, b_q;
    logic [4:0]        shamt_d, shamt_q;
    logic [2:0]        func_d, func_q;
    logic [2:0]        rd_d, rd_q;
    logic              illegal_d, illegal_q;
    logic [3:0]        opcode_q;
    logic              valid_q;

    assign in_ready = !valid_q || ex_ready;
    assign accept_s = in_valid && in_ready;
    assign rs_s     = in_instr[11:9];
    assign rt_s     = in_instr[8:6];

    // Register-file write port; r0 is never written and stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_en && (wb_addr == 3'(i))) begin
                    rf_q[i] <= wb_data;
                end
            end
        end
    end

    // Operand read with write-through bypass of the writeback happening this cycle.
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        if (rs_s == 3'd0) begin
            op_a_s = '0;
        end else if (wb_en && (wb_addr == rs_s)) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = rf_q[rs_s];
        end
        if (rt_s == 3'd0) begin
            op_b_s = '0;
        end else if (wb_en && (wb_addr == rt_s)) begin
            op_b_s = wb_data;
        end else begin
            op_b_s = rf_q[rt_s];
        end
    end

    // Instruction decode into the execute-facing fields.
    always_comb begin
        a_d       = '0;
        b_d       = '0;
        shamt_d   = 5'd0;
        func_d    = 3'd0;
        rd_d      = 3'd0;
        illegal_d = 1'b0;
        case (in_instr[15:12])
            4'h0: begin
                a_d    = op_a_s;
                b_d    = op_b_s;
                func_d = in_instr[2:0];
                rd_d   = in_instr[5:3];
            end
            4'h1: begin
                // Shift amounts 16..31 pass through untouched; execute saturates them.
                a_d     = op_a_s;
                shamt_d = in_instr[5:1];
                func_d  = {2'b00, in_instr[0]};
                rd_d    = in_instr[8:6];
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // One-entry pipeline register towards execute; fields freeze while stalled or drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            shamt_q   <= 5'd0;
            opcode_q  <= 4'd0;
            func_q    <= 3'd0;
            rd_q      <= 3'd0;
            illegal_q <= 1'b0;
        end else if (accept_s) begin
            valid_q   <= 1'b1;
            a_q       <= a_d;
            b_q       <= b_d;
            shamt_q   <= shamt_d;
            opcode_q  <= in_instr[15:12];
            func_q    <= func_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end else if (ex_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_a       = a_q;
    assign ex_b       = b_q;
    assign ex_shamt   = shamt_q;
    assign ex_opcode  = opcode_q;
    assign ex_func    = func_q;
    assign ex_rd      = rd_q;
    assign ex_illegal = illegal_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode and operand-fetch stage of the 16-bit CPU. It sits directly upstream of the execute stage that contains the SLL shifter and the ALU. It accepts one 16-bit instruction per cycle, decodes it, and reads operands from an internal 8x16 register file with writeback bypass. It then presents registered operands (A, B, shamt) and control fields to execute over a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 16, datapath and register width.
- NREG, 8, number of architectural registers; r0 reads as 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an instruction is offered.
- in_instr  in  16  instruction word.
- in_ready  out  1  stage can accept an instruction this cycle.
- wb_en  in  1  register-file write enable from writeback.
- wb_addr  in  3  write address.
- wb_data  in  16  write data.
- ex_valid  out  1  ex_* fields hold a valid instruction.
- ex_ready  in  1  execute consumes the current instruction.
- ex_a  out  16  first operand (feeds shifter A).
- ex_b  out  16  second operand.
- ex_shamt  out  5  shift amount (feeds shifter shamt).
- ex_opcode  out  4  instr[15:12].
- ex_func  out  3  function code.
- ex_rd  out  3  destination register.
- ex_illegal  out  1  opcode not supported.

## Operation
Decoding:
- opcode = instr[15:12].
- R-type (opcode 4'h0):
  - rs = [11:9], rt = [8:6], rd = [5:3], func = [2:0].
  - ex_a = R[rs], ex_b = R[rt], ex_shamt = 0.
- Shift-type (opcode 4'h1):
  - rs = [11:9], rd = [8:6], shamt = [5:1], dir = [0] (0 = SLL, 1 = SRL).
  - ex_a = R[rs], ex_b = 0, ex_shamt = shamt, ex_func = {2'b00, dir}.
  - Shamt 16..31 passes unmodified; execute resolves it to result 0.
- Any other opcode:
  - ex_illegal = 1; ex_a = ex_b = 0, ex_shamt = 0, ex_rd = 0, ex_func = 0.
  - The instruction still flows through with ex_valid so execute can trap.

Register file:
- 8 x 16 flops, written on the rising edge when wb_en = 1 and wb_addr != 0.
- Read of r0 always returns 0.

Bypass:
- If a read address equals wb_addr, wb_en = 1, and the address != 0, the operand captured is wb_data.
- This is same-cycle write-through: it applies in the cycle the instruction is accepted.

Handshake:
- Accept when in_valid && in_ready.
- in_ready = !ex_valid || ex_ready, combinational, giving one-entry pipeline register behaviour.
- On accept, all ex_* fields load and ex_valid is set to 1.
- If ex_valid && ex_ready && !in_valid, ex_valid clears and the ex_* fields hold their last values.
- While ex_valid && !ex_ready (stall), all ex_* fields are frozen. A writeback during the stall updates the register file but not the held operands. Hazard interlock belongs to the pipeline controller.

## Timing
- Reset asserted:
  - ex_valid = 0, so in_ready = 1.
  - ex_a, ex_b, ex_shamt, ex_opcode, ex_func, ex_rd, ex_illegal are all 0.
  - All registers are 0.
- Reset mid-stall discards the held instruction; nothing is replayed.
- Latency: 1 cycle from accept edge to ex_valid.
- Throughput: 1 instruction per cycle when ex_ready is held at 1.
- Simultaneous accept and consume in the same cycle: the new instruction replaces the old; ex_valid stays 1 with no bubble.
- Simultaneous wb to rs and rt with rs == rt: both operands take wb_data.
- wb_addr = 0 with wb_en = 1: no write and no bypass; operand reads 0.

## Test plan
- Reset → every ex_* field is 0 and in_ready = 1. Any register read after reset returns 0.
- Write r1 = 3, then issue 16'h1284 (SLL r2, r1, 2) → next cycle ex_a = 3, ex_shamt = 2, ex_rd = 2, ex_func = 0, ex_illegal = 0. Downstream SLL yields 12.
- Bypass: issue 16'h1286 in the same cycle as wb_en = 1, wb_addr = 1, wb_data = 5 → ex_a = 5, ex_shamt = 3. Downstream SLL yields 40.
- Stall:
  - Hold ex_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0 and ex_* is frozen.
  - Write r1 = 9 during the stall → ex_a stays at its old value.
  - Release ex_ready → the next instruction loads in the same cycle with no bubble.
- R-type with r3 = 16'hFFFF, r4 = 16'h0001 and instruction 16'h0728 (rs = 3, rt = 4, rd = 5, func = 0) → ex_a = FFFF, ex_b = 0001, ex_rd = 5. Opcode 4'hF → ex_illegal = 1, ex_valid = 1, operands 0.
- Assert rst while ex_valid = 1 and stalled → outputs clear immediately, without waiting for clk. After release, the first accepted instruction appears 1 cycle later.
